// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection controller.
// Lamps are active-low G/B/R triples.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_BLUE    = 2'd2,
        ST_FLASH   = 2'd3
    } state_e;

    localparam logic [2:0] LED_GREEN = 3'b110;
    localparam logic [2:0] LED_BLUE  = 3'b101;
    localparam logic [2:0] LED_RED   = 3'b011;
    localparam logic [2:0] LED_OFF   = 3'b111;

    // One approach's lamp triple as a pure function of the controller state.
    function automatic logic [2:0] lamp_pattern(state_e st, logic is_active, logic flash_off);
        logic [2:0] pat;
        pat = LED_RED;
        case (st)
            ST_GREEN: pat = is_active ? LED_GREEN : LED_RED;
            ST_BLUE:  pat = is_active ? LED_BLUE : LED_RED;
            ST_FLASH: pat = flash_off ? LED_OFF : LED_BLUE;
            default:  pat = LED_RED;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/appr_arbiter.sv
// Round-robin pick of the next approach to serve from the demand latches.
// The current approach is considered last; with no demand it simply rotates.
module appr_arbiter #(
    parameter int NUM_APPR = 2
) (
    input  logic [NUM_APPR-1:0] pend,
    input  logic [1:0]          active_appr,
    output logic [1:0]          next_appr
);

    always_comb begin
        next_appr = 2'((int'(active_appr) + 1) % NUM_APPR);
        // Walk the scan order backwards so the earliest pending slot is written last.
        for (int i = NUM_APPR; i >= 1; i--) begin
            for (int k = 0; k < NUM_APPR; k++) begin
                if (pend[k] && (k == (int'(active_appr) + i) % NUM_APPR)) begin
                    next_appr = 2'(k);
                end
            end
        end
    end

endmodule

// File: rtl/traffic_signal_ctrl.sv
// Multi-approach intersection controller: green -> blue -> all-red per approach
// with demand-based skipping. Optional night flash under TRAFFIC_NIGHT_FLASH_EN.
module traffic_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_APPR     = 2,
    parameter int GREEN_TICKS  = 120_000_000,
    parameter int BLUE_TICKS   = 48_000_000,
    parameter int ALLRED_TICKS = 24_000_000,
    parameter int FLASH_TICKS  = 12_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_APPR-1:0]   veh_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic                  night_mode,
`endif
    output logic [3*NUM_APPR-1:0] led,
    output logic [1:0]            active_appr,
    output logic [1:0]            phase
);

    localparam int MAX_GB = (GREEN_TICKS > BLUE_TICKS) ? GREEN_TICKS : BLUE_TICKS;
    localparam int MAX_AF = (ALLRED_TICKS > FLASH_TICKS) ? ALLRED_TICKS : FLASH_TICKS;
    localparam int MAX_T  = (MAX_GB > MAX_AF) ? MAX_GB : MAX_AF;
    localparam int CW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CW-1:0] G_LIM  = CW'(GREEN_TICKS - 1);
    localparam logic [CW-1:0] B_LIM  = CW'(BLUE_TICKS - 1);
    localparam logic [CW-1:0] AR_LIM = CW'(ALLRED_TICKS - 1);
`ifdef TRAFFIC_NIGHT_FLASH_EN
    localparam logic [CW-1:0] F_LIM  = CW'(FLASH_TICKS - 1);
`endif

    state_e                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [NUM_APPR-1:0]     pend_reg, pend_next;
    logic                    flash_reg, flash_next;
    logic [1:0]              active_next;
    logic [1:0]              pick;
    logic [3*NUM_APPR-1:0]   led_next;

    appr_arbiter #(.NUM_APPR(NUM_APPR)) u_arbiter (
        .pend        (pend_reg),
        .active_appr (active_appr),
        .next_appr   (pick)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CW'(1);
        pend_next   = pend_reg | veh_req;
        flash_next  = flash_reg;
        active_next = active_appr;
        case (state_reg)
            ST_ALL_RED: begin
                if (cnt_reg == AR_LIM) begin
                    cnt_next = '0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    if (night_mode) begin
                        state_next = ST_FLASH;
                        flash_next = 1'b0;
                    end else
`endif
                    begin
                        state_next  = ST_GREEN;
                        active_next = pick;
                        // Entry into green consumes this approach's demand, even a fresh request.
                        for (int k = 0; k < NUM_APPR; k++) begin
                            if (pick == 2'(k)) pend_next[k] = 1'b0;
                        end
                    end
                end
            end
            ST_GREEN: begin
                if (cnt_reg == G_LIM) begin
                    cnt_next   = '0;
                    state_next = ST_BLUE;
                end
            end
            ST_BLUE: begin
                if (cnt_reg == B_LIM) begin
                    cnt_next   = '0;
                    state_next = ST_ALL_RED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    if (night_mode) begin
                        state_next = ST_FLASH;
                        flash_next = 1'b0;
                    end
`endif
                end
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            ST_FLASH: begin
                if (cnt_reg == F_LIM) begin
                    cnt_next = '0;
                    if (!night_mode) state_next = ST_ALL_RED;
                    else             flash_next = ~flash_reg;
                end
            end
`endif
            default: begin
                state_next = ST_ALL_RED;
                cnt_next   = '0;
            end
        endcase
    end

    // Lamps are registered from the next-state view so they change with the state.
    generate
        for (genvar gi = 0; gi < NUM_APPR; gi++) begin : g_lamp
            assign led_next[3*gi +: 3] = lamp_pattern(state_next, active_next == 2'(gi), flash_next);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_ALL_RED;
            cnt_reg     <= '0;
            pend_reg    <= '0;
            flash_reg   <= 1'b0;
            active_appr <= 2'(NUM_APPR - 1);
            led         <= {NUM_APPR{LED_RED}};
            phase       <= 2'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pend_reg    <= pend_next;
            flash_reg   <= flash_next;
            active_appr <= active_next;
            led         <= led_next;
            phase       <= state_next;
        end
    end

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// Randomized and directed bench for traffic_signal_ctrl against a countdown
// reference model; flash scenario included when TRAFFIC_NIGHT_FLASH_EN is defined.
module tb_traffic_signal_ctrl;

    localparam int N  = 4;
    localparam int GT = 5;
    localparam int BT = 2;
    localparam int AT = 3;
    localparam int FT = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   veh_req = '0;
    logic           night_mode = 1'b0;
    logic [3*N-1:0] led;
    logic [1:0]     active_appr;
    logic [1:0]     phase;

    traffic_signal_ctrl #(
        .NUM_APPR(N), .GREEN_TICKS(GT), .BLUE_TICKS(BT),
        .ALLRED_TICKS(AT), .FLASH_TICKS(FT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .veh_req     (veh_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night_mode  (night_mode),
`endif
        .led         (led),
        .active_appr (active_appr),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase name, cycles left in the phase, served approach, demand set.
    int           m_phase = 0;
    int           m_left  = AT;
    int           m_act   = N - 1;
    logic [N-1:0] m_pend  = '0;
    bit           m_flash = 1'b0;
    bit           m_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    function automatic int next_served(input logic [N-1:0] pend, input int cur);
        for (int i = 1; i <= N; i++) begin
            if (pend[(cur + i) % N]) return (cur + i) % N;
        end
        return (cur + 1) % N;
    endfunction

    function automatic bit night_now();
`ifdef TRAFFIC_NIGHT_FLASH_EN
        return night_mode;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_update();
        logic [N-1:0] old_pend;
        int nxt;
        if (rst) begin
            m_phase = 0; m_left = AT; m_act = N - 1; m_pend = '0; m_flash = 1'b0; m_valid = 1'b1;
            return;
        end
        old_pend = m_pend;
        m_pend   = m_pend | veh_req;
        m_left--;
        if (m_left == 0) begin
            case (m_phase)
                0: if (night_now()) begin
                       m_phase = 3; m_left = FT; m_flash = 1'b0;
                   end else begin
                       nxt = next_served(old_pend, m_act);
                       m_phase = 1; m_left = GT; m_act = nxt; m_pend[nxt] = 1'b0;
                       $display("serve approach %0d at cycle %0d", nxt, cyc);
                   end
                1: begin m_phase = 2; m_left = BT; end
                2: if (night_now()) begin
                       m_phase = 3; m_left = FT; m_flash = 1'b0;
                   end else begin
                       m_phase = 0; m_left = AT;
                   end
                default: if (!night_now()) begin
                       m_phase = 0; m_left = AT;
                   end else begin
                       m_flash = ~m_flash; m_left = FT;
                   end
            endcase
        end
    endtask

    function automatic logic [3*N-1:0] model_led();
        logic [3*N-1:0] v;
        for (int k = 0; k < N; k++) begin
            v[3*k +: 3] = 3'b011;
            if (m_phase == 1 && k == m_act) v[3*k +: 3] = 3'b110;
            if (m_phase == 2 && k == m_act) v[3*k +: 3] = 3'b101;
            if (m_phase == 3) v[3*k +: 3] = m_flash ? 3'b111 : 3'b101;
        end
        return v;
    endfunction

    task automatic compare_all();
        int lit;
        logic [2:0] tri_v;
        logic [3*N-1:0] led_v;
        if (!m_valid) return;
        check_eq("led", 32'(led), 32'(model_led()));
        check_eq("phase", 32'(phase), 32'(m_phase));
        check_eq("active", 32'(active_appr), 32'(m_act));
        lit = 0;
        led_v = led;
        for (int k = 0; k < N; k++) begin
            tri_v = led_v[3*k +: 3];
            if (tri_v != 3'b011 && m_phase != 3) lit++;
        end
        check_eq("one_non_red", 32'(lit <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    int first_g;
    int g_len;
    bit seen;

    initial begin
        // Reset state and first-green timing with no demand.
        veh_req = '0;
        do_reset();
        check_eq("rst_led", 32'(led), 32'({N{3'b011}}));
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_active", 32'(active_appr), 32'(N - 1));
        first_g = -1;
        while (cyc < 13) begin
            tick();
            if (first_g < 0 && phase == 2'd1) first_g = cyc;
        end
        check_eq("first_green_cycle", 32'(first_g), 32'd3);
        check_eq("appr1_green_at_13", 32'({phase, active_appr}), 32'({2'd1, 2'd1}));

        // Single pulse on approach 2 during approach 0 green: 2 served next.
        do_reset();
        run_to(5);
        veh_req = 4'b0100;
        tick();
        veh_req = '0;
        run_to(13);
        check_eq("skip_to_appr2", 32'({phase, active_appr}), 32'({2'd1, 2'd2}));

        // Toggling demand mid-green never changes the green length.
        do_reset();
        g_len = 0;
        while (cyc < 13) begin
            if (cyc == 5) veh_req = 4'b0010;
            if (cyc == 6) veh_req = 4'b0000;
            tick();
            if (phase == 2'd1 && active_appr == 2'd0) g_len++;
        end
        check_eq("green_len", 32'(g_len), 32'd5);
        check_eq("appr1_next", 32'({phase, active_appr}), 32'({2'd1, 2'd1}));

        // Reset asserted mid-blue.
        do_reset();
        run_to(8);
        check_eq("in_blue", 32'(phase), 32'd2);
        rst = 1'b1;
        tick();
        check_eq("midrst_led", 32'(led), 32'({N{3'b011}}));
        check_eq("midrst_phase", 32'(phase), 32'd0);
        rst = 1'b0;
        cyc = 0;
        run_to(3);
        check_eq("midrst_green0", 32'({phase, active_appr}), 32'({2'd1, 2'd0}));

        // Random demand with occasional resets, checked every cycle.
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < N; k++) veh_req[k] = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        veh_req = '0;

`ifdef TRAFFIC_NIGHT_FLASH_EN
        // Night flash requested mid-green, then released.
        do_reset();
        run_to(5);
        night_mode = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (phase == 2'd3) seen = 1'b1;
        end
        check_eq("flash_reached", 32'(seen), 32'd1);
        check_eq("flash_on", 32'(led), 32'({N{3'b101}}));
        repeat (FT) tick();
        check_eq("flash_off", 32'(led), 32'({N{3'b111}}));
        repeat (FT + 1) tick();
        night_mode = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (phase == 2'd0) seen = 1'b1;
        end
        check_eq("flash_exit", 32'(seen), 32'd1);
        check_eq("flash_exit_led", 32'(led), 32'({N{3'b011}}));
        repeat (20) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_signal_ctrl.md
# traffic_signal_ctrl

Parametrised multi-approach intersection controller; next generation of the single-lamp traffic signal. Drives N approaches with active-low G/B/R lamp triples. Sequences green → blue (amber) → all-red clearance per approach, with demand-based skipping of idle approaches. Sits directly between the board clock and the LED pins; one instance per intersection.

## Interface
- `NUM_APPR`, 2 — number of approaches (2..4)
- `GREEN_TICKS`, 120_000_000 — green duration in clk cycles (≥1)
- `BLUE_TICKS`, 48_000_000 — blue (amber) duration in clk cycles (≥1)
- `ALLRED_TICKS`, 24_000_000 — all-red clearance in clk cycles (≥1)
- `FLASH_TICKS`, 12_000_000 — half-period of night flash (≥1; used only with macro)
- `clk`  in  1 — system clock
- `rst`  in  1 — synchronous, active-high reset
- `veh_req`  in  NUM_APPR — per-approach demand, level, sampled every cycle
- `night_mode`  in  1 — night flash request (present only with macro)
- `led`  out  3*NUM_APPR — lamps, active-low; triple k = `led[3k+2:3k]`: 3'b110 green, 3'b101 blue, 3'b011 red
- `active_appr`  out  2 — approach currently served (or last served during all-red)
- `phase`  out  2 — 0 ALL_RED, 1 GREEN, 2 BLUE, 3 FLASH

## Operation
- States: ALL_RED, GREEN, BLUE, FLASH (FLASH only with macro).
- ALL_RED: every triple 3'b011. GREEN/BLUE: triple `active_appr` shows 3'b110/3'b101, all others 3'b011.
- Transitions: ALL_RED →(ALLRED_TICKS elapsed)→ GREEN of next approach; GREEN →(GREEN_TICKS)→ BLUE; BLUE →(BLUE_TICKS)→ ALL_RED.
- Demand latch `pend[k]`: set when `veh_req[k]`=1, cleared on the cycle approach k enters GREEN. Set wins over clear only if `veh_req[k]` still high in the entry cycle of another approach; a request asserted in the GREEN-entry cycle of k itself is discarded.
- Next-approach selection at end of ALL_RED: first k with `pend[k]`=1, scanning round-robin from `active_appr`+1. If no pend bit set: plain rotation, `active_appr`+1 mod NUM_APPR. Active approach is eligible only after all others are scanned.
- Only one approach ever non-red; no state yields two non-red triples.
- Output pattern is a pure function of state, `active_appr`, flash toggle; no lamp is written by bit rotation.

## Timing
- Reset (synchronous): state ALL_RED, counter 0, `active_appr` = NUM_APPR-1 (so approach 0 served first under no demand), `pend` = 0, `led` all 3'b011, `phase` 0, flash toggle 0.
- All outputs registered; state change visible the cycle after the terminal count.
- Each state lasts exactly its TICKS count: counter runs 0..TICKS-1, state advances when counter = TICKS-1, counter returns to 0.
- Counter width `$clog2` of largest TICKS parameter; no wrap inside a state.
- First green after reset appears at cycle ALLRED_TICKS after `rst` deasserts.
- `rst` mid-state: next cycle all red, timing restarts from ALL_RED; pending demand lost.
- `veh_req` change mid-GREEN/BLUE never shortens or extends the running phase.

## Configuration
- `TRAFFIC_NIGHT_FLASH_EN` defined: `night_mode` port exists. `night_mode`=1 sampled at end of BLUE or ALL_RED (never mid-green) → FLASH: all triples alternate 3'b101 / 3'b111 every FLASH_TICKS, starting 3'b101. `night_mode`=0 in FLASH → ALL_RED with counter 0 at the next flash half-period boundary; `pend` kept.
- Undefined: no `night_mode` port, no FLASH state, `phase` never 3.

## Structure
- Package `traffic_pkg`: state enum, lamp constants LED_GREEN 3'b110, LED_BLUE 3'b101, LED_RED 3'b011, LED_OFF 3'b111.
- One sub-module: `appr_arbiter` — combinational round-robin pick from `pend` and `active_appr`, returns next index.

## Test plan
- Reset, NUM_APPR=2, G/B/AR=5/2/3, `veh_req`=0 → cycles 0–2 all red; approach 0 green cycles 3–7, blue 8–9, all red 10–12, approach 1 green from 13.
- Same, `veh_req`=2'b00 except `veh_req[2]` pulsed once, NUM_APPR=4 → after approach 0 served, approach 2 green next; approaches 1, 3 skipped.
- `veh_req[1]` toggled mid-green of approach 0 → green still exactly 5 cycles; approach 1 served next.
- `rst` asserted mid-BLUE → next cycle `led` all 3'b011, `phase` 0, green for approach 0 after 3 cycles.
- Every cycle of a 1000-cycle random-request run: at most one triple ≠ 3'b011.
- Macro defined, FLASH_TICKS=4, `night_mode`=1 during green → green/blue complete, then all 3'b101 four cycles, 3'b111 four cycles, repeat; drop `night_mode` → all red at next boundary.
